// File: rtl/spi_slave.sv
// SPI target with oversampled pins: decodes a write/size/address control header,
// then issues one register write or read strobe per frame.
module spi_slave #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              sck,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              reg_wr,
    output logic              reg_rd,
    output logic [AWIDTH-1:0] reg_addr,
    output logic [1:0]        reg_size,
    output logic [DWIDTH-1:0] reg_wdata,
    input  logic [DWIDTH-1:0] reg_rdata,
    output logic              frame_err
);
    localparam int unsigned CW   = AWIDTH + 3;
    localparam int unsigned CNTW = 6;

    typedef enum logic [1:0] {IDLE, CTRL, DATA, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        sck_q;
    logic [1:0]        ss_q, mosi_q;
    logic              ss_prev_q;
    logic [CNTW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]     ctrl_sr_q, ctrl_sr_d;
    logic [DWIDTH-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
    logic              wr_q, wr_d, shift_q, cap_q;
    logic              reg_wr_q, reg_wr_d, reg_rd_q, reg_rd_d, err_q, err_d;
    logic              miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic [AWIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [1:0]        reg_size_q, reg_size_d;
    logic [DWIDTH-1:0] reg_wdata_q, reg_wdata_d;

    logic              sample, ss_hi, ss_fall, ctrl_last, data_last, c_bad;
    logic [CW-1:0]     ctrl_word;
    logic [1:0]        c_size;
    int unsigned       nbits;
    logic [CNTW-1:0]   last_cnt;
    logic [DWIDTH-1:0] tx_load;

    // Pin synchronizers; the ss history flop resets low so a frame needs ss_n high then low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_q     <= '0;
            ss_q      <= '0;
            mosi_q    <= '0;
            ss_prev_q <= 1'b0;
        end else begin
            sck_q     <= {sck_q[1:0], sck};
            ss_q      <= {ss_q[0], ss_n};
            mosi_q    <= {mosi_q[0], mosi};
            ss_prev_q <= ss_q[1];
        end
    end

    assign sample    = (mode[1] ^ mode[0]) ? (~sck_q[1] & sck_q[2]) : (sck_q[1] & ~sck_q[2]);
    assign ss_hi     = ss_q[1];
    assign ss_fall   = ss_prev_q & ~ss_q[1];
    assign ctrl_word = {ctrl_sr_q[CW-2:0], mosi_q[1]};
    assign c_size    = ctrl_word[AWIDTH+1:AWIDTH];
    assign c_bad     = (c_size == 2'b11) || ((32'd8 << c_size) > DWIDTH);
    assign ctrl_last = sample && (bit_cnt_q == CNTW'(CW - 1));
    assign nbits     = 32'd8 << reg_size_q;
    assign last_cnt  = CNTW'(nbits - 32'd1);
    assign data_last = sample && (bit_cnt_q == last_cnt);
    assign tx_load   = reg_rdata << (DWIDTH - nbits);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Completion of the last data bit outranks a simultaneous ss_n rise
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ss_fall) state_d = CTRL;
            CTRL: begin
                if (ss_hi)          state_d = IDLE;
                else if (ctrl_last) state_d = c_bad ? DONE : DATA;
            end
            DATA: begin
                if (data_last)  state_d = DONE;
                else if (ss_hi) state_d = IDLE;
            end
            DONE: if (ss_hi) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        ctrl_sr_d   = ctrl_sr_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        wr_d        = wr_q;
        reg_addr_d  = reg_addr_q;
        reg_size_d  = reg_size_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    bit_cnt_d = '0;
                    ctrl_sr_d = '0;
                    rx_sr_d   = '0;
                    tx_sr_d   = '0;
                end
            end
            CTRL: begin
                if (ss_hi) begin
                    err_d = 1'b1;
                end else if (sample) begin
                    ctrl_sr_d = ctrl_word;
                    bit_cnt_d = bit_cnt_q + CNTW'(1);
                    if (ctrl_last) begin
                        bit_cnt_d = '0;
                        if (c_bad) begin
                            err_d = 1'b1;
                        end else begin
                            wr_d       = ctrl_word[CW-1];
                            reg_size_d = c_size;
                            reg_addr_d = ctrl_word[AWIDTH-1:0];
                            reg_rd_d   = ~ctrl_word[CW-1];
                        end
                    end
                end
            end
            DATA: begin
                if (ss_hi && !data_last) begin
                    err_d = 1'b1;
                end else if (sample) begin
                    bit_cnt_d = bit_cnt_q + CNTW'(1);
                    if (wr_q) begin
                        rx_sr_d = {rx_sr_q[DWIDTH-2:0], mosi_q[1]};
                        if (data_last) begin
                            reg_wr_d    = 1'b1;
                            reg_wdata_d = rx_sr_d;
                        end
                    end
                end
                // Read data lands MSB-aligned; each bit moves out one clk after its sample edge
                if (!wr_q) begin
                    if (cap_q)        tx_sr_d = tx_load;
                    else if (shift_q) tx_sr_d = {tx_sr_q[DWIDTH-2:0], 1'b0};
                end
            end
            default: ;
        endcase
        miso_oe_d = (state_d == DATA) && !wr_d;
        miso_d    = miso_oe_d && tx_sr_d[DWIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            ctrl_sr_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            wr_q        <= 1'b0;
            shift_q     <= 1'b0;
            cap_q       <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            err_q       <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            reg_addr_q  <= '0;
            reg_size_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            ctrl_sr_q   <= ctrl_sr_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            wr_q        <= wr_d;
            shift_q     <= sample;
            cap_q       <= reg_rd_q;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            err_q       <= err_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_size_q  <= reg_size_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;
    assign reg_wr    = reg_wr_q;
    assign reg_rd    = reg_rd_q;
    assign frame_err = err_q;
    assign reg_addr  = reg_addr_q;
    assign reg_size  = reg_size_q;
    assign reg_wdata = reg_wdata_q;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DWIDTH, default 32: data field width in bits; legal values are 8, 16 or 32.
REQ-002 Parameter AWIDTH, default 8: register address width in bits.
REQ-003 clk  in  1: single system clock; SPI pins are oversampled in this domain.
REQ-004 rst_n  in  1: reset, synchronous and active-low.
REQ-005 mode  in  2: SPI mode {cpol,cpha}; must be static while ss_n is low.
REQ-006 sck  in  1: SPI serial clock from the master; asynchronous to clk.
REQ-007 ss_n  in  1: slave select, active-low; asynchronous to clk.
REQ-008 mosi  in  1: master-to-slave serial data.
REQ-009 miso  out  1: slave-to-master serial data.
REQ-010 miso_oe  out  1: miso output enable; the top level builds the tristate from it.
REQ-011 reg_wr  out  1: one-cycle register write strobe.
REQ-012 reg_rd  out  1: one-cycle register read strobe.
REQ-013 reg_addr  out  AWIDTH: register address for reg_wr and reg_rd.
REQ-014 reg_size  out  2: access size; 00 = 8 bits, 01 = 16 bits, 10 = 32 bits.
REQ-015 reg_wdata  out  DWIDTH: write data, right-aligned and zero-extended.
REQ-016 reg_rdata  in  DWIDTH: read data, right-aligned; valid on the cycle after reg_rd.
REQ-017 frame_err  out  1: one-cycle pulse on an aborted or illegal frame.

Function
REQ-018 sck, ss_n and mosi shall each pass through a 2-flop synchronizer; a third flop on sck shall provide edge detection.
REQ-019 The sample edge shall be the rising sck edge when cpol XOR cpha = 0, and the falling edge otherwise; detection lags the pin by 3 clk at most.
REQ-020 Legal sck half-period shall be at least 4 clk, i.e. the master's fixed divider.
REQ-021 Frame format shall be MSB first: write(1), size(2), addr(AWIDTH), then N data bits, with N = 8, 16 or 32 from size.
REQ-022 The FSM shall have four states: IDLE, CTRL, DATA, DONE.
REQ-023 IDLE -> CTRL when synchronized ss_n falls; the bit counter clears and the shift registers clear.
REQ-024 CTRL: on each sample edge, shift mosi into the control shift register and increment bit_cnt (6 bits); after AWIDTH+3 bits, latch write, size and addr, clear bit_cnt, and go to DATA.
REQ-025 Size 2'b11, or N > DWIDTH, in CTRL: pulse frame_err, and ignore the rest of the frame (no strobes) until ss_n rises, then go to IDLE.
REQ-026 Read (write = 0): assert reg_rd for exactly 1 clk on the cycle after the last control bit is sampled; capture reg_rdata[N-1:0] on the next clk into tx_sr, MSB aligned.
REQ-027 DATA write: on each sample edge, shift mosi into rx_sr; after N bits go to DONE.
REQ-028 DATA read: miso = tx_sr MSB; shift tx_sr left one clk after each sample edge is detected; after N bits go to DONE.
REQ-029 miso_oe shall be 1 only in DATA for a read frame, with ss_n low; otherwise 0, and miso shall be 0.
REQ-030 DONE, write frame: assert reg_wr for 1 clk with reg_wdata = {zeros, rx_sr[N-1:0]} and reg_addr/reg_size held; then wait for ss_n to rise and go to IDLE.
REQ-031 Extra sck edges in DONE shall be ignored, with no counter wrap and no second strobe.
REQ-032 ss_n rising in CTRL or DATA shall abort the frame: pulse frame_err, no reg_wr, go to IDLE on the next clk.
REQ-033 ss_n rising on the same clk as the last data sample shall complete the frame; the completion takes priority and reg_wr is issued.
REQ-034 reg_addr, reg_size and reg_wdata shall hold their values between frames.

Reset
REQ-035 rst_n low at a clk edge shall force: state IDLE; counters and shift registers 0; reg_wr, reg_rd, frame_err, miso_oe and miso all 0; reg_addr, reg_size and reg_wdata all 0.
REQ-036 Reset asserted mid-frame shall discard the frame; the block shall not leave IDLE until ss_n is seen high then low.

Verification
REQ-037 Mode 00, write, size 10, addr 0x5A, data 0xDEADBEEF -> a single reg_wr with reg_addr = 0x5A, reg_size = 10, reg_wdata = 0xDEADBEEF.
REQ-038 Mode 00, write, size 00, addr 0x03, data byte 0xA5 -> reg_wdata = 0x000000A5; no frame_err.
REQ-039 Modes 01/10/11, read, size 01, addr 0x10, reg_rdata = 0x00001234 -> reg_rd once; miso bits over 16 sample edges = 0x1234; miso_oe low outside DATA.
REQ-040 ss_n raised after 5 data bits of a write -> frame_err pulses once; no reg_wr; the next frame completes normally.
REQ-041 Size 11 frame -> frame_err pulses; no reg_rd or reg_wr; IDLE after ss_n rises.
REQ-042 rst_n low for 1 clk during CTRL -> all outputs 0; the following full frame decodes correctly.
